seg_bus_decoder: RTL and testbench
==================================

Name: seg_bus_decoder

Overview:
- Decodes the eight-digit multiplexed seven-segment bus back into a 32-bit hex value: the receiving end of the scanned display interface.
- Samples the active-low digit select and the active-low segment pattern, waits until each (select, pattern) pair has settled, and maps the pattern back to a nibble.
- Assembles a full frame of eight digits and publishes the value.
- Used for on-board loopback/self-check of display paths and as a bench monitor for display drivers.

Parameters:
- SETTLE_CYCLES, 4, consecutive identical samples required before a pair is accepted; legal range 2..255.
- CNT_W, 8, width of the settle counter; must hold SETTLE_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- seg_number  in  8  segment pattern, active-low, bit7 = dp, bit0 = a
- seg_choice  in  8  digit select, active-low one-hot; bit7 low = digit 0 (value[3:0]) … bit0 low = digit 7 (value[31:28])
- digit_strobe  out  1  one-cycle pulse: a digit was accepted
- digit_idx  out  3  index of the accepted digit, valid with digit_strobe
- digit_val  out  4  decoded nibble, valid with digit_strobe
- value_out  out  32  last complete frame
- digit_mask  out  8  bit i set = digit i captured in the current frame
- frame_valid  out  1  one-cycle pulse: value_out was just updated
- err_pattern  out  1  one-cycle pulse: settled pattern is not in the decode table

Behaviour:
- Reset: all outputs 0; input sample registers = 8'hFF/8'hFF; state IDLE; counter 0; shadow register 0.
- Input stage: seg_number and seg_choice are registered every cycle. All logic uses the registered pair and compares it with the previous registered pair.
- Select validity: exactly one bit of seg_choice is 0. All-ones, all-zeros and multi-low selects are invalid.
- Decode table (pattern → nibble):
  - C0→0, F9→1, A4→2, B0→3, 99→4, 92→5, 82→6, F8→7, 80→8, 90→9
  - 88→A, BF ("-")→A
  - 83→B, C6→C, A1→D, 86→E, 8E→F
  - FF (blank) → no digit; not an error.
  - Any other value → error.
- States:
  - IDLE: select invalid. Go to SETTLE with counter 0 when a valid select is sampled.
  - SETTLE: the counter increments while the pair equals the previous sample. Any change in the pair restarts the counter at 0, or returns to IDLE if the select became invalid. When SETTLE_CYCLES consecutive identical samples have been seen, commit and go to HOLD.
  - HOLD: no further commits for this pair. Any change in the pair goes to SETTLE (counter 0) or IDLE. This prevents re-strobing one digit across a long dwell.
- Commit, registered on one edge:
  - Pattern in table: digit_strobe=1, digit_idx/digit_val driven, shadow nibble[idx] written, digit_mask[idx] set.
  - Blank: nothing happens.
  - Unknown pattern: err_pattern=1; shadow and mask unchanged.
- Latency: a pair first present at the inputs before edge k produces digit_strobe high after edge k+SETTLE_CYCLES (one input register edge plus SETTLE_CYCLES sample edges).
- Frame completion:
  - When a commit makes digit_mask all ones, on the same edge: value_out = shadow including the new nibble, frame_valid=1, digit_mask cleared to 0.
  - Digits may arrive in any order. Re-committing an already-captured digit before frame completion overwrites its shadow nibble; the mask is unchanged.
- Transient tolerance: the driver updates select one cycle before pattern. The one-cycle mismatched pair restarts settling and is never committed when SETTLE_CYCLES ≥ 2.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). A partial frame is discarded and value_out reads 0.
- Outputs are registered; no combinational input-to-output path.

Test Plan:
- Full frame: drive the scan of 32'h1234_5678, dwelling 20 cycles per digit.
  - Digit 0 is pair (7F,80), … digit 7 is pair (FE,F9).
  - Required: eight digit_strobes with idx 0..7 and values 8,7,6,5,4,3,2,1, then frame_valid once with value_out=32'h1234_5678 and digit_mask=0.
- Settle/latency, SETTLE_CYCLES=4: apply (BF,C0) before edge 10 and hold.
  - Required: digit_strobe exactly after edge 14, idx=1, val=0, and only once across a 100-cycle dwell.
- Skew glitch: select switches to FB one cycle before the pattern switches from 99 to A4.
  - Required: no strobe for (FB,99); a single strobe idx=5, val=2.
- Error and blank:
  - Pattern 8'h55 on digit 3 → one err_pattern pulse; mask bit 3 stays 0.
  - Pattern FF → no strobe and no error.
  - Invalid select 8'h00 or 8'hF3 → state IDLE, no strobe.
- Dash and out-of-order:
  - Digits committed in order 7,0,3,1,6,2,5,4 with digit 2 = BF and digit 0 rewritten from 1 to 9 before completion.
  - Required: frame_valid once; value_out nibble 2 = A and nibble 0 = 9.
- Reset mid-frame: assert rst after 5 digits.
  - Required: all outputs 0 immediately. A following complete scan yields a correct frame with no residue from the aborted one.

Source files
------------

// File: rtl/seg_bus_decoder.sv
// Receiver for an eight-digit multiplexed seven-segment bus: settles each
// (select, pattern) pair, decodes it to a nibble and assembles 32-bit frames.
module seg_bus_decoder #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  seg_number,
   input  logic [7:0]  seg_choice,
   output logic        digit_strobe,
   output logic [2:0]  digit_idx,
   output logic [3:0]  digit_val,
   output logic [31:0] value_out,
   output logic [7:0]  digit_mask,
   output logic        frame_valid,
   output logic        err_pattern
);

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [7:0]        num_q, sel_q, num_p, sel_p;
   logic [31:0]       shadow;

   logic              changed_c, sel_ok_c, known_c, blank_c, commit_c;
   logic [7:0]        sel_inv_c, mask_nx_c;
   logic [2:0]        idx_c;
   logic [3:0]        nib_c;
   logic [31:0]       shadow_nx_c;

   // Pair comparison and select validity (exactly one low bit)
   always_comb begin
      changed_c = (num_q != num_p) || (sel_q != sel_p);
      sel_inv_c = ~sel_q;
      sel_ok_c  = (sel_inv_c != 8'h00) && ((sel_inv_c & (sel_inv_c - 8'd1)) == 8'h00);
      idx_c     = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (!sel_q[7-i]) idx_c = 3'(i);
      end
   end

   // Segment pattern back to nibble; blank is neither digit nor error
   always_comb begin
      known_c = 1'b1;
      blank_c = 1'b0;
      nib_c   = 4'h0;
      case (num_q)
         8'hC0: nib_c = 4'h0;
         8'hF9: nib_c = 4'h1;
         8'hA4: nib_c = 4'h2;
         8'hB0: nib_c = 4'h3;
         8'h99: nib_c = 4'h4;
         8'h92: nib_c = 4'h5;
         8'h82: nib_c = 4'h6;
         8'hF8: nib_c = 4'h7;
         8'h80: nib_c = 4'h8;
         8'h90: nib_c = 4'h9;
         8'h88: nib_c = 4'hA;
         8'hBF: nib_c = 4'hA;
         8'h83: nib_c = 4'hB;
         8'hC6: nib_c = 4'hC;
         8'hA1: nib_c = 4'hD;
         8'h86: nib_c = 4'hE;
         8'h8E: nib_c = 4'hF;
         8'hFF: begin
            known_c = 1'b0;
            blank_c = 1'b1;
         end
         default: known_c = 1'b0;
      endcase
   end

   // Next shadow/mask as they would look if this commit lands
   always_comb begin
      shadow_nx_c                      = shadow;
      shadow_nx_c[{idx_c, 2'b00} +: 4] = nib_c;
      mask_nx_c                        = digit_mask | (8'd1 << idx_c);
      commit_c = (state == SETTLE) && !changed_c &&
                 (cnt == CNT_W'(SETTLE_CYCLES - 2));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         num_q        <= 8'hFF;
         sel_q        <= 8'hFF;
         num_p        <= 8'hFF;
         sel_p        <= 8'hFF;
         shadow       <= '0;
         digit_strobe <= 1'b0;
         digit_idx    <= '0;
         digit_val    <= '0;
         value_out    <= '0;
         digit_mask   <= '0;
         frame_valid  <= 1'b0;
         err_pattern  <= 1'b0;
      end else begin
         num_q        <= seg_number;
         sel_q        <= seg_choice;
         num_p        <= num_q;
         sel_p        <= sel_q;
         digit_strobe <= 1'b0;
         frame_valid  <= 1'b0;
         err_pattern  <= 1'b0;
         case (state)
            IDLE: begin
               if (sel_ok_c) begin
                  state <= SETTLE;
                  cnt   <= '0;
               end
            end
            SETTLE: begin
               if (changed_c) begin
                  cnt   <= '0;
                  state <= sel_ok_c ? SETTLE : IDLE;
               end else if (commit_c) begin
                  state <= HOLD;
                  if (known_c) begin
                     digit_strobe <= 1'b1;
                     digit_idx    <= idx_c;
                     digit_val    <= nib_c;
                     shadow       <= shadow_nx_c;
                     if (mask_nx_c == 8'hFF) begin
                        value_out   <= shadow_nx_c;
                        frame_valid <= 1'b1;
                        digit_mask  <= '0;
                     end else begin
                        digit_mask  <= mask_nx_c;
                     end
                  end else if (!blank_c) begin
                     err_pattern <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            HOLD: begin
               // A long dwell on one pair must not re-strobe
               if (changed_c) begin
                  cnt   <= '0;
                  state <= sel_ok_c ? SETTLE : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_bus_decoder.sv
// Bench for seg_bus_decoder: per-cycle reference model of the bus protocol,
// a table of single-digit vectors and hand-written scan/reset/glitch sequences.
module tb_seg_bus_decoder;

   localparam int unsigned SETTLE = 4;

   logic        clk, rst;
   logic [7:0]  seg_number, seg_choice;
   logic        digit_strobe, frame_valid, err_pattern;
   logic [2:0]  digit_idx;
   logic [3:0]  digit_val;
   logic [31:0] value_out;
   logic [7:0]  digit_mask;

   seg_bus_decoder #(.SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .seg_number(seg_number), .seg_choice(seg_choice),
      .digit_strobe(digit_strobe), .digit_idx(digit_idx), .digit_val(digit_val),
      .value_out(value_out), .digit_mask(digit_mask), .frame_valid(frame_valid),
      .err_pattern(err_pattern)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Reference model state
   logic [3:0]  m_shadow [8];
   logic [7:0]  m_mask;
   logic [31:0] m_value;
   logic [7:0]  run_sel, run_num;
   int          run_len;
   logic [7:0]  cur_num;

   // Observed activity
   int          strobe_cnt, frame_cnt, err_cnt;
   logic [2:0]  last_idx;
   logic [3:0]  last_val;
   logic [2:0]  log_idx [$];
   logic [3:0]  log_val [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] dec_pat(input logic [7:0] p);
      if (p == 8'hBF) return {1'b1, 4'hA};
      for (int i = 0; i < 16; i++) if (seg_tab[i] == p) return {1'b1, 4'(i)};
      return 5'd0;
   endfunction

   function automatic bit sel_valid(input logic [7:0] s);
      int z = 0;
      for (int i = 0; i < 8; i++) if (!s[i]) z++;
      return z == 1;
   endfunction

   function automatic int sel_idx(input logic [7:0] s);
      for (int i = 0; i < 8; i++) if (!s[7-i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_shadow[i] = 4'h0;
      m_mask  = 8'h00;
      m_value = 32'h0;
      run_sel = 8'hFF;
      run_num = 8'hFF;
      run_len = 1000;
   endtask

   // One clock with inputs (s, n); model predicts and all outputs are compared
   task automatic step(input logic [7:0] s, input logic [7:0] n);
      logic       e_strobe, e_err, e_frame;
      logic [4:0] d;
      int         ei;
      seg_choice = s;
      seg_number = n;
      cur_num    = n;
      @(posedge clk);
      #1;
      e_strobe = 1'b0; e_err = 1'b0; e_frame = 1'b0; ei = 0; d = 5'd0;
      if (run_len == SETTLE && sel_valid(run_sel)) begin
         d  = dec_pat(run_num);
         ei = sel_idx(run_sel);
         if (d[4]) begin
            e_strobe     = 1'b1;
            m_shadow[ei] = d[3:0];
            m_mask[ei]   = 1'b1;
            if (m_mask == 8'hFF) begin
               for (int i = 0; i < 8; i++) m_value[4*i +: 4] = m_shadow[i];
               m_mask  = 8'h00;
               e_frame = 1'b1;
            end
         end else if (run_num != 8'hFF) begin
            e_err = 1'b1;
         end
      end
      if (s == run_sel && n == run_num) begin
         if (run_len < 1000) run_len++;
      end else begin
         run_sel = s;
         run_num = n;
         run_len = 1;
      end
      chk("digit_strobe", 32'(digit_strobe), 32'(e_strobe));
      chk("err_pattern", 32'(err_pattern), 32'(e_err));
      chk("frame_valid", 32'(frame_valid), 32'(e_frame));
      chk("digit_mask", 32'(digit_mask), 32'(m_mask));
      chk("value_out", value_out, m_value);
      if (e_strobe) begin
         chk("digit_idx", 32'(digit_idx), 32'(ei));
         chk("digit_val", 32'(digit_val), 32'(d[3:0]));
      end
      if (digit_strobe) begin
         strobe_cnt++;
         last_idx = digit_idx;
         last_val = digit_val;
         log_idx.push_back(digit_idx);
         log_val.push_back(digit_val);
      end
      if (frame_valid) frame_cnt++;
      if (err_pattern) err_cnt++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst digit_strobe", 32'(digit_strobe), 32'd0);
      chk("rst digit_idx", 32'(digit_idx), 32'd0);
      chk("rst digit_val", 32'(digit_val), 32'd0);
      chk("rst value_out", value_out, 32'd0);
      chk("rst digit_mask", 32'(digit_mask), 32'd0);
      chk("rst frame_valid", 32'(frame_valid), 32'd0);
      chk("rst err_pattern", 32'(err_pattern), 32'd0);
      seg_choice = 8'hFF;
      seg_number = 8'hFF;
      cur_num    = 8'hFF;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      model_reset();
   endtask

   // Driver behaviour: select moves one cycle before the pattern
   task automatic put_digit(input int i, input logic [7:0] pat, input int dwell);
      logic [7:0] s;
      s = 8'h80 >> i;
      s = ~s;
      step(s, cur_num);
      repeat (dwell - 1) step(s, pat);
   endtask

   task automatic scan(input logic [31:0] v, input int ndig);
      for (int i = 0; i < ndig; i++) put_digit(i, seg_tab[v[4*i +: 4]], 20);
   endtask

   typedef struct {
      logic [7:0] sel;
      logic [7:0] num;
      int         strobes;
      logic [2:0] idx;
      logic [3:0] val;
      int         errs;
   } vec_t;

   vec_t vecs [11];

   initial begin
      int s0, f0, e0, first;
      logic [7:0] rs, rn;
      vecs[0]  = '{8'h7F, 8'h80, 1, 3'd0, 4'h8, 0};
      vecs[1]  = '{8'hBF, 8'hC0, 1, 3'd1, 4'h0, 0};
      vecs[2]  = '{8'hDF, 8'hBF, 1, 3'd2, 4'hA, 0};
      vecs[3]  = '{8'hEF, 8'h55, 0, 3'd0, 4'h0, 1};
      vecs[4]  = '{8'hF7, 8'hFF, 0, 3'd0, 4'h0, 0};
      vecs[5]  = '{8'hFB, 8'h88, 1, 3'd5, 4'hA, 0};
      vecs[6]  = '{8'hFD, 8'h8E, 1, 3'd6, 4'hF, 0};
      vecs[7]  = '{8'hFE, 8'h83, 1, 3'd7, 4'hB, 0};
      vecs[8]  = '{8'h00, 8'hC0, 0, 3'd0, 4'h0, 0};
      vecs[9]  = '{8'hF3, 8'hC0, 0, 3'd0, 4'h0, 0};
      vecs[10] = '{8'hEF, 8'hA1, 1, 3'd3, 4'hD, 0};
      strobe_cnt = 0; frame_cnt = 0; err_cnt = 0;
      last_idx = '0; last_val = '0;
      rst = 1'b1;
      seg_choice = 8'hFF;
      seg_number = 8'hFF;
      #12;
      do_reset();

      // Single-digit vectors
      foreach (vecs[k]) begin
         step(8'hFF, 8'hFF);
         step(8'hFF, 8'hFF);
         s0 = strobe_cnt; e0 = err_cnt;
         repeat (12) step(vecs[k].sel, vecs[k].num);
         chk("vec strobes", 32'(strobe_cnt - s0), 32'(vecs[k].strobes));
         chk("vec errors", 32'(err_cnt - e0), 32'(vecs[k].errs));
         if (vecs[k].strobes == 1) begin
            chk("vec idx", 32'(last_idx), 32'(vecs[k].idx));
            chk("vec val", 32'(last_val), 32'(vecs[k].val));
         end
         if (k == 3) chk("err keeps mask bit3", 32'(digit_mask[3]), 32'd0);
      end

      // Reset with seven digits captured, then a full scan
      do_reset();
      log_idx.delete(); log_val.delete();
      f0 = frame_cnt;
      scan(32'h1234_5678, 8);
      chk("scan strobes", 32'(log_idx.size()), 32'd8);
      for (int i = 0; i < 8 && i < log_idx.size(); i++) begin
         chk("scan idx", 32'(log_idx[i]), 32'(i));
         chk("scan val", 32'(log_val[i]), 32'(8 - i));
      end
      chk("scan frames", 32'(frame_cnt - f0), 32'd1);
      chk("scan value", value_out, 32'h1234_5678);
      chk("scan mask", 32'(digit_mask), 32'd0);

      // Latency: strobe exactly SETTLE edges after the first sampling edge
      repeat (3) step(8'hFF, 8'hFF);
      s0 = strobe_cnt; first = -1;
      for (int n = 0; n < 100; n++) begin
         step(8'hBF, 8'hC0);
         if (digit_strobe && first < 0) first = n;
      end
      chk("latency edge", 32'(first), 32'(SETTLE));
      chk("latency once", 32'(strobe_cnt - s0), 32'd1);
      chk("latency idx", 32'(last_idx), 32'd1);
      chk("latency val", 32'(last_val), 32'd0);

      // Select/pattern skew: (FB,99) must never commit
      put_digit(4, 8'h99, 20);
      s0 = strobe_cnt;
      put_digit(5, 8'hA4, 20);
      chk("skew strobes", 32'(strobe_cnt - s0), 32'd1);
      chk("skew idx", 32'(last_idx), 32'd5);
      chk("skew val", 32'(last_val), 32'd2);

      // Out-of-order with dash and a rewrite of digit 0
      do_reset();
      f0 = frame_cnt;
      put_digit(7, 8'hC6, 10);
      put_digit(0, 8'hF9, 10);
      put_digit(3, 8'hB0, 10);
      put_digit(1, 8'hA4, 10);
      put_digit(6, 8'h82, 10);
      put_digit(0, 8'h90, 10);
      chk("ooo mask before end", 32'(digit_mask), 32'hCB);
      put_digit(2, 8'hBF, 10);
      put_digit(5, 8'h92, 10);
      chk("ooo no frame yet", 32'(frame_cnt - f0), 32'd0);
      put_digit(4, 8'h99, 10);
      chk("ooo frames", 32'(frame_cnt - f0), 32'd1);
      chk("ooo value", value_out, 32'hC654_3A29);

      // Reset after five digits, then a clean frame
      scan(32'hDEAD_BEEF, 5);
      do_reset();
      f0 = frame_cnt;
      scan(32'hDEAD_BEEF, 8);
      chk("post-reset frames", 32'(frame_cnt - f0), 32'd1);
      chk("post-reset value", value_out, 32'hDEAD_BEEF);

      // Randomized bus activity against the model
      for (int seg = 0; seg < 1500; seg++) begin
         int r = $urandom_range(0, 9);
         if (r < 8)       rs = ~(8'd1 << $urandom_range(0, 7));
         else if (r == 8) rs = 8'hFF;
         else             rs = 8'($urandom);
         r = $urandom_range(0, 9);
         if (r < 6)       rn = seg_tab[$urandom_range(0, 15)];
         else if (r == 6) rn = 8'hBF;
         else if (r == 7) rn = 8'hFF;
         else             rn = 8'($urandom);
         repeat ($urandom_range(1, 8)) step(rs, rn);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
